// File: rtl/spi_regif.sv
// SPI slave register interface: 16-bit frames (R/W, 7-bit address, 8-bit data)
// bridging a serial host to a parallel register file. Everything runs on sclk.
module spi_regif #(
  parameter int REGCOUNT = 14
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       csn,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] dout,
  output logic       wre,
  output logic [7:0] addr,
  output logic [7:0] din,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  // Upper bound of the implemented address range, one bit wider than addr
  localparam logic [8:0] REG_LIM = 9'(REGCOUNT);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        rw_reg;
  logic [5:0]  asr_reg;   // address bits from edges 1..6; edge 7 bit comes straight from mosi
  logic [6:0]  dsr_reg;   // data bits from edges 8..14; edge 15 bit comes straight from mosi
  logic [6:0]  msr_reg;   // remaining read bits still to be presented on miso

  logic       addr_ok;
  logic [7:0] rd_sel;

  // Out-of-range addresses read as zero and never strobe a write
  assign addr_ok = ({1'b0, addr} < REG_LIM);
  assign rd_sel  = addr_ok ? dout : 8'h00;

  // Frame state machine with all outputs registered
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      rw_reg    <= 1'b0;
      asr_reg   <= 6'd0;
      dsr_reg   <= 7'd0;
      msr_reg   <= 7'd0;
      miso      <= 1'b0;
      wre       <= 1'b0;
      addr      <= 8'h00;
      din       <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      // The write strobe lasts exactly one edge whatever csn does
      wre <= 1'b0;
      case (state_reg)
        IDLE: begin
          miso <= 1'b0;
          if (!csn) begin
            rw_reg    <= mosi;
            cnt_reg   <= 4'd1;
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          if (csn) begin
            // Aborted frame: leave addr/din untouched, flag the error
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            miso      <= 1'b0;
            frame_err <= 1'b1;
          end else begin
            asr_reg <= {asr_reg[4:0], mosi};
            cnt_reg <= cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              addr      <= {1'b0, asr_reg, mosi};
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (csn) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            miso      <= 1'b0;
            frame_err <= 1'b1;
          end else begin
            dsr_reg <= {dsr_reg[5:0], mosi};
            cnt_reg <= cnt_reg + 4'd1;
            if (rw_reg) begin
              miso <= 1'b0;
            end else if (cnt_reg == 4'd8) begin
              // addr settled at edge 7, so dout is valid for capture here
              miso    <= rd_sel[7];
              msr_reg <= rd_sel[6:0];
            end else begin
              miso    <= msr_reg[6];
              msr_reg <= {msr_reg[5:0], 1'b0};
            end
            if (cnt_reg == 4'd15) begin
              state_reg <= DONE;
              if (rw_reg) begin
                din <= {dsr_reg, mosi};
                wre <= addr_ok;
              end
            end
          end
        end
        DONE: begin
          // Extra edges inside the frame are ignored until csn rises
          miso <= 1'b0;
          if (csn) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 4'd0;
          miso      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regif.sv
// Directed bench for spi_regif: drives frames on falling sclk, samples 1 time
// unit after each rising edge, and keeps a small register file behind dout.
module tb_spi_regif;

  logic       sclk;
  logic       rstn;
  logic       csn;
  logic       mosi;
  logic       miso;
  logic [7:0] dout;
  logic       wre;
  logic [7:0] addr;
  logic [7:0] din;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [16];

  spi_regif #(.REGCOUNT(14)) dut (
    .sclk(sclk), .rstn(rstn), .csn(csn), .mosi(mosi), .miso(miso),
    .dout(dout), .wre(wre), .addr(addr), .din(din), .frame_err(frame_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Bench register file: 0xFF everywhere except 0x5C at address 2
  always @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
      mem[2] <= 8'h5C;
    end else if (wre) begin
      mem[addr[3:0]] <= din;
    end
  end

  assign dout = mem[addr[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Clock nbits edges of a frame with csn low; edges past 15 send 1s
  task automatic xfer(input logic [15:0] word, input int nbits,
                      output logic [7:0] rd, output logic wre15, output int stray);
    rd = 8'h00; wre15 = 1'b0; stray = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge sclk);
      csn  = 1'b0;
      mosi = (i < 16) ? word[15-i] : 1'b1;
      @(posedge sclk);
      #1;
      if (i >= 8 && i < 16) rd[15-i] = miso;
      else if (miso) stray++;
      if (i == 15) wre15 = wre;
      else if (wre) stray++;
    end
  endtask

  // One edge with csn high
  task automatic gap();
    @(negedge sclk);
    csn  = 1'b1;
    mosi = 1'b0;
    @(posedge sclk);
    #1;
  endtask

  logic [7:0] rd;
  logic       w15;
  int         stray;

  initial begin
    rstn = 1'b0; csn = 1'b1; mosi = 1'b0;
    #12;
    check("rst_wre", {31'd0, wre}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'h00);
    check("rst_din", {24'd0, din}, 32'h00);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    @(negedge sclk); rstn = 1'b1;
    gap();

    // Write 0x03 <= 0xA5
    xfer({1'b1, 7'h03, 8'hA5}, 16, rd, w15, stray);
    check("wr3_wre15", {31'd0, w15}, 32'd1);
    check("wr3_addr", {24'd0, addr}, 32'h03);
    check("wr3_din", {24'd0, din}, 32'hA5);
    check("wr3_miso", {24'd0, rd}, 32'h00);
    check("wr3_stray", stray, 32'd0);
    gap();
    check("wr3_wre_drop", {31'd0, wre}, 32'd0);

    // Read 0x02 with dout = 0x5C
    xfer({1'b0, 7'h02, 8'h00}, 16, rd, w15, stray);
    check("rd2_miso", {24'd0, rd}, 32'h5C);
    check("rd2_wre15", {31'd0, w15}, 32'd0);
    check("rd2_stray", stray, 32'd0);
    check("rd2_din", {24'd0, din}, 32'hA5);
    check("rd2_addr", {24'd0, addr}, 32'h02);
    gap();
    check("rd2_miso_after", {31'd0, miso}, 32'd0);

    // Read back what was written to 0x03
    xfer({1'b0, 7'h03, 8'h00}, 16, rd, w15, stray);
    check("rd3_miso", {24'd0, rd}, 32'hA5);
    gap();

    // Out-of-range write and read at 0x0E
    xfer({1'b1, 7'h0E, 8'h3C}, 16, rd, w15, stray);
    check("wrE_wre15", {31'd0, w15}, 32'd0);
    check("wrE_din", {24'd0, din}, 32'h3C);
    check("wrE_addr", {24'd0, addr}, 32'h0E);
    gap();
    xfer({1'b0, 7'h0E, 8'h00}, 16, rd, w15, stray);
    check("rdE_miso", {24'd0, rd}, 32'h00);
    check("rdE_stray", stray, 32'd0);
    gap();

    // Abort after edge 10 of a write
    xfer({1'b1, 7'h05, 8'h77}, 11, rd, w15, stray);
    gap();
    check("abt_wre", {31'd0, wre}, 32'd0);
    check("abt_stray", stray, 32'd0);
    check("abt_ferr", {31'd0, frame_err}, 32'd1);
    check("abt_din", {24'd0, din}, 32'h3C);
    check("abt_addr", {24'd0, addr}, 32'h05);
    xfer({1'b1, 7'h04, 8'h99}, 16, rd, w15, stray);
    check("post_abt_wre15", {31'd0, w15}, 32'd1);
    check("post_abt_din", {24'd0, din}, 32'h99);
    check("post_abt_ferr", {31'd0, frame_err}, 32'd1);
    gap();

    // Reset pulse after edge 12 of a write
    xfer({1'b1, 7'h06, 8'h12}, 13, rd, w15, stray);
    @(negedge sclk); rstn = 1'b0; csn = 1'b1;
    #1;
    check("mrst_wre", {31'd0, wre}, 32'd0);
    check("mrst_addr", {24'd0, addr}, 32'h00);
    check("mrst_din", {24'd0, din}, 32'h00);
    check("mrst_ferr", {31'd0, frame_err}, 32'd0);
    check("mrst_stray", stray, 32'd0);
    @(negedge sclk); rstn = 1'b1;
    gap();
    check("mrst_idle_wre", {31'd0, wre}, 32'd0);
    xfer({1'b1, 7'h07, 8'hC3}, 16, rd, w15, stray);
    check("post_rst_wre15", {31'd0, w15}, 32'd1);
    check("post_rst_addr", {24'd0, addr}, 32'h07);
    check("post_rst_din", {24'd0, din}, 32'hC3);
    gap();

    // Back-to-back writes with a single csn-high edge between
    xfer({1'b1, 7'h08, 8'h11}, 16, rd, w15, stray);
    check("b2b1_wre15", {31'd0, w15}, 32'd1);
    check("b2b1_addr", {24'd0, addr}, 32'h08);
    check("b2b1_din", {24'd0, din}, 32'h11);
    gap();
    check("b2b1_drop", {31'd0, wre}, 32'd0);
    xfer({1'b1, 7'h09, 8'h22}, 16, rd, w15, stray);
    check("b2b2_wre15", {31'd0, w15}, 32'd1);
    check("b2b2_addr", {24'd0, addr}, 32'h09);
    check("b2b2_din", {24'd0, din}, 32'h22);
    check("b2b2_stray", stray, 32'd0);
    gap();
    xfer({1'b0, 7'h08, 8'h00}, 16, rd, w15, stray);
    check("rd8_miso", {24'd0, rd}, 32'h11);
    gap();
    xfer({1'b0, 7'h09, 8'h00}, 16, rd, w15, stray);
    check("rd9_miso", {24'd0, rd}, 32'h22);
    gap();

    // Extra edges after edge 15 are ignored
    xfer({1'b1, 7'h01, 8'h5A}, 19, rd, w15, stray);
    check("ext_wre15", {31'd0, w15}, 32'd1);
    check("ext_stray", stray, 32'd0);
    check("ext_din", {24'd0, din}, 32'h5A);
    check("ext_addr", {24'd0, addr}, 32'h01);
    gap();
    check("ext_ferr", {31'd0, frame_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_regif.md
SPI_REGIF -- requirements
Module: spi_regif

Interface
REQ-001 Parameter REGCOUNT, default 14: number of implemented registers; valid addresses are 0..REGCOUNT-1.
REQ-002 sclk  input  1  serial clock, sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 csn  input  1  chip select, active-low, sampled on sclk rising edge.
REQ-005 mosi  input  1  serial data in, MSB first, sampled on sclk rising edge.
REQ-006 miso  output  1  serial data out, registered, changes only after sclk rising edge.
REQ-007 dout  input  8  register read data, combinational function of addr.
REQ-008 wre  output  1  register write strobe, registered, one sclk cycle wide.
REQ-009 addr  output  8  register address, registered.
REQ-010 din  output  8  register write data, registered.
REQ-011 frame_err  output  1  sticky flag: frame aborted by csn high before completion.

Function
REQ-012 Frame: 16 bits; edge k = k-th rising edge with csn low (k=0..15); edge 0 = R/W (1 = write); edges 1..7 = address bits 6..0; edges 8..15 = data bits 7..0.
REQ-013 States: IDLE, ADDR, DATA, DONE; 4-bit edge counter.
REQ-014 IDLE: csn low -> capture R/W, counter=1, go ADDR; csn high -> stay.
REQ-015 ADDR: shift mosi into address shift register; at edge 7 load addr = {1'b0, a[6:0]}, go DATA.
REQ-016 DATA: shift mosi into data shift register; at edge 15 go DONE.
REQ-017 DONE: ignore mosi/extra edges while csn low; csn sampled high -> IDLE.
REQ-018 Any state except IDLE/DONE: csn sampled high -> IDLE, counter=0, no wre, frame_err=1, addr/din unchanged.
REQ-019 Write frame (R/W=1) with addr < REGCOUNT: din loaded with data byte and wre=1 on edge 15; wre=0 on next edge, irrespective of csn.
REQ-020 Write with addr >= REGCOUNT: no wre pulse; din still updated.
REQ-021 Read frame (R/W=0): at edge 8 load miso shift register with dout (or 8'h00 if addr >= REGCOUNT); miso = bit 7 after edge 8, bit 6 after edge 9, ..., bit 0 after edge 15.
REQ-022 miso = 0 at all other times, including write frames and after edge 15.
REQ-023 Read frames never assert wre and never change din.
REQ-024 addr holds until edge 7 of the next frame; din holds until edge 15 of the next write frame.
REQ-025 The write takes effect at the sclk edge after edge 15; host shall supply at least one sclk edge with csn high between frames.
REQ-026 Back-to-back frames: csn high for exactly one edge after edge 15 -> next frame edge 0 on the following edge, no data loss.
REQ-027 frame_err cleared only by rstn.

Reset
REQ-028 rstn low asynchronously forces: state IDLE, counter 0, wre 0, addr 8'h00, din 8'h00, miso 0, frame_err 0, shift registers 0.
REQ-029 rstn low mid-frame aborts frame with no wre pulse; first frame after release starts at edge 0.

Verification
REQ-030 Write frame 1_0000011_A5 then one csn-high edge -> addr=8'h03, din=8'hA5, wre high exactly one cycle after edge 15.
REQ-031 Read frame 0_0000010_xx with dout=8'h5C -> miso sequence 0,1,0,1,1,1,0,0 after edges 8..15; wre stays 0.
REQ-032 Write to address 8'h0E (REGCOUNT=14) -> no wre; read of 8'h0E -> miso all zeros.
REQ-033 csn high after edge 10 of a write -> IDLE, no wre, frame_err=1, din unchanged; next full frame completes normally.
REQ-034 rstn pulsed low at edge 12 of a write -> all outputs at reset values immediately, no wre; subsequent frame correct.
REQ-035 Two back-to-back write frames with one csn-high edge between -> two wre pulses with correct addr/din each.
